x_adc_demux_4ch: RTL and testbench
==================================

Name: x_adc_demux_4ch

Overview:
- De-interleaver for the x4 interleaved ADC path; the inverse of the 4-channel x_adc selection mux.
- Accepts a single serial 32-bit sample stream and distributes consecutive samples round-robin into four per-channel holding registers (channel 0..3).
- Emits per-channel write strobes and a frame strobe once all four channels of a frame have been written.
- Sync input aligns sample-to-channel mapping; misalignment is detected and flagged.

Parameters:
- DATA_W, 32, sample width in bits.
- SYNC_MODE, 1, 1 = wait for first x_adc_sync before capturing; 0 = capture from reset with channel 0 first.

Ports:
- clk  input  1  system clock, all logic on rising edge
- GlobalReset  input  1  synchronous, active-high reset
- x_adc  input  DATA_W  incoming serial sample
- x_adc_valid  input  1  sample on x_adc valid this cycle
- x_adc_sync  input  1  qualifies the current valid sample as channel 0; ignored when x_adc_valid=0
- err_clear  input  1  clears sync_err
- x_adc_0 .. x_adc_3  output  DATA_W each  per-channel holding registers
- ch_valid  output  4  one-cycle pulse, bit n = x_adc_n updated this cycle
- frame_valid  output  1  one-cycle pulse, channels 0..3 of one aligned frame complete
- x_adc_select  output  2  channel index the next valid sample will be written to
- locked  output  1  1 in RUN state
- sync_err  output  1  sticky misalignment flag

Behaviour:
- Reset (GlobalReset=1 at a clk edge): x_adc_0..3=0, ch_valid=0, frame_valid=0, x_adc_select=0, sync_err=0. State = WAIT_SYNC if SYNC_MODE=1, else RUN. Reset mid-frame discards the partial frame; no strobes follow.
- States: WAIT_SYNC, RUN. locked=1 only in RUN.
- WAIT_SYNC: valid samples without sync are dropped (no strobes). valid&sync -> write x_adc_0, ch_valid=4'b0001 next cycle, x_adc_select=1, go RUN.
- RUN, valid & !sync: write x_adc_[x_adc_select]; ch_valid bit set next cycle; x_adc_select increments mod 4 (3 -> 0 wraps).
- RUN, valid & sync with x_adc_select==0: normal channel 0 write, identical to above.
- RUN, valid & sync with x_adc_select!=0: resync. Write x_adc_0, ch_valid=4'b0001, x_adc_select=1, sync_err<=1. Partial frame is discarded: frame_valid is not raised until channels 1..3 of the new frame are written.
- frame_valid pulses in the same cycle as ch_valid[3], only if channels 0..3 were written consecutively since the last channel-0 write. Track this with an internal frame_ok bit, cleared on resync and reset.
- Latency: 1 cycle from x_adc_valid at edge k to holding register and strobe visible after edge k+1.
- x_adc_valid=0: registers hold, ch_valid=0, frame_valid=0, x_adc_select unchanged. Gaps of any length are allowed mid-frame.
- Holding registers keep their value until overwritten; they are never cleared except by reset.
- sync_err: set on resync; cleared by err_clear. If set and clear occur in the same cycle, set wins. Not set by the first sync in WAIT_SYNC.
- With SYNC_MODE=0 the block starts in RUN with x_adc_select=0. Sync remains honoured for realignment.
- ch_valid is one-hot or zero; never more than one bit set.

Decomposition:
- Shared package holds:
  - the channel count constant NUM_CH=4 and the index width 2;
  - the state encoding (WAIT_SYNC=1'b0, RUN=1'b1);
  - the default DATA_W, shared with the x_adc selection mux.
- One natural sub-module: x_adc_ch_ptr. It holds the mod-4 pointer, resync load-to-1, the frame_ok tracker and the frame_valid generation.
- Top level holds the FSM, the four holding registers, the strobe decode and sync_err.

Test Plan:
- Basic frame: SYNC_MODE=1, reset, then valid samples 0xA0,0xA1(sync=0),… with sync on the first. Sequence 0xA0(sync),0xA1,0xA2,0xA3 -> x_adc_0..3=A0..A3, ch_valid 1,2,4,8 on consecutive cycles, frame_valid with ch_valid=8, x_adc_select back to 0.
- Pre-sync drop: 0x11,0x22 without sync then 0x33(sync) -> only x_adc_0=0x33, locked rises with first strobe, all others remain 0.
- Gaps: frame 0xB0(sync),gap×3,0xB1,gap,0xB2,0xB3 -> same strobes, delayed, one frame_valid, x_adc_select holds during gaps.
- Misalignment: after 0xC0(sync),0xC1, send 0xD0(sync),0xD1,0xD2,0xD3 -> sync_err=1, x_adc_0=0xD0, no frame_valid for the C-frame, frame_valid on 0xD3. Then err_clear=1 -> sync_err=0. Repeat with err_clear coincident with a resync -> sync_err stays 1.
- Reset mid-frame: 0xE0(sync),0xE1, GlobalReset=1 one cycle -> all outputs 0, state WAIT_SYNC. Subsequent 0xE2 (no sync) dropped.
- SYNC_MODE=0: after reset feed 0xF0..0xF3 with no sync -> captured into channels 0..3, frame_valid on 0xF3, locked=1 from reset.

Source files
------------

// File: rtl/x_adc_demux_4ch_pkg.sv
// Shared constants, state encoding and helpers for the x4 ADC de-interleaver.
package x_adc_demux_4ch_pkg;

    localparam int NUM_CH         = 4;
    localparam int IDX_W          = 2;
    // Same default sample width as the x_adc selection mux.
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        WAIT_SYNC = 1'b0,
        RUN       = 1'b1
    } state_t;

    // One-hot strobe for a channel index.
    function automatic logic [NUM_CH-1:0] ch_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_CH-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/x_adc_demux_4ch_if.sv
// Serial interleaved sample stream feeding the de-interleaver.
interface x_adc_demux_4ch_if
    import x_adc_demux_4ch_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) ();

    logic [DATA_W-1:0] x_adc;
    logic              x_adc_valid;
    logic              x_adc_sync;

    modport master (output x_adc, output x_adc_valid, output x_adc_sync);
    modport slave  (input  x_adc, input  x_adc_valid, input  x_adc_sync);

endinterface

// File: rtl/x_adc_ch_ptr.sv
// Round-robin channel pointer with sync reload and frame-complete tracking.
module x_adc_ch_ptr
    import x_adc_demux_4ch_pkg::*;
(
    input  logic             clk,
    input  logic             GlobalReset,
    input  logic             adv,          // a sample is being written this cycle
    input  logic             load,         // that sample is forced to channel 0
    output logic [IDX_W-1:0] sel,          // channel the next sample goes to
    output logic [IDX_W-1:0] wr_idx,       // channel the current sample goes to
    output logic             frame_valid
);

    logic [IDX_W-1:0] sel_q;
    logic             frame_ok_q;
    logic             frame_valid_q;

    // Target channel for the current sample: sync overrides the pointer.
    always_comb begin
        wr_idx = load ? '0 : sel_q;
    end

    // Pointer advance, frame tracking and the frame-complete pulse.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            sel_q         <= '0;
            frame_ok_q    <= 1'b0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            if (adv) begin
                sel_q <= load ? IDX_W'(1) : sel_q + IDX_W'(1);
                if (wr_idx == '0) begin
                    // Every channel-0 write (including a resync) starts a fresh frame.
                    frame_ok_q <= 1'b1;
                end else if (wr_idx == IDX_W'(NUM_CH - 1)) begin
                    frame_valid_q <= frame_ok_q;
                    frame_ok_q    <= 1'b0;
                end
            end
        end
    end

    assign sel         = sel_q;
    assign frame_valid = frame_valid_q;

endmodule

// File: rtl/x_adc_demux_4ch.sv
// De-interleaves a serial x4 ADC sample stream into four channel registers.
module x_adc_demux_4ch
    import x_adc_demux_4ch_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit SYNC_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                GlobalReset,
    x_adc_demux_4ch_if.slave    adc,
    input  logic                err_clear,
    output logic [DATA_W-1:0]   x_adc_0,
    output logic [DATA_W-1:0]   x_adc_1,
    output logic [DATA_W-1:0]   x_adc_2,
    output logic [DATA_W-1:0]   x_adc_3,
    output logic [NUM_CH-1:0]   ch_valid,
    output logic                frame_valid,
    output logic [IDX_W-1:0]    x_adc_select,
    output logic                locked,
    output logic                sync_err
);

    localparam state_t RESET_STATE = SYNC_MODE ? WAIT_SYNC : RUN;

    state_t           state_q, state_d;
    logic             accept, load, resync;
    logic [IDX_W-1:0] sel, wr_idx;

    logic [DATA_W-1:0] hold_q [NUM_CH];
    logic [NUM_CH-1:0] ch_valid_q;
    logic              sync_err_q;

    // Next state and per-sample decisions.
    // NOTE: every output of this block is given a default first so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        load    = 1'b0;
        resync  = 1'b0;
        case (state_q)
            WAIT_SYNC: begin
                if (adc.x_adc_valid && adc.x_adc_sync) begin
                    accept  = 1'b1;
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (adc.x_adc_valid) begin
                    accept = 1'b1;
                    load   = adc.x_adc_sync;
                    resync = adc.x_adc_sync && (sel != '0);
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (GlobalReset) state_q <= RESET_STATE;
        else             state_q <= state_d;
    end

    x_adc_ch_ptr u_ptr (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .adv         (accept),
        .load        (load),
        .sel         (sel),
        .wr_idx      (wr_idx),
        .frame_valid (frame_valid)
    );

    // Holding registers: write the addressed channel, otherwise hold.
    // NOTE: this small register array is reset on purpose so downstream logic
    // never sees undefined samples; larger sample stores would be left unreset.
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            for (int i = 0; i < NUM_CH; i++) hold_q[i] <= '0;
        end else if (accept) begin
            hold_q[wr_idx] <= adc.x_adc;
        end
    end

    // One-cycle channel write strobe, one-hot or zero.
    always_ff @(posedge clk) begin
        if (GlobalReset) ch_valid_q <= '0;
        else             ch_valid_q <= accept ? ch_onehot(wr_idx) : '0;
    end

    // Sticky misalignment flag; a resync wins over a coincident clear.
    always_ff @(posedge clk) begin
        if (GlobalReset)    sync_err_q <= 1'b0;
        else if (resync)    sync_err_q <= 1'b1;
        else if (err_clear) sync_err_q <= 1'b0;
    end

    assign x_adc_0      = hold_q[0];
    assign x_adc_1      = hold_q[1];
    assign x_adc_2      = hold_q[2];
    assign x_adc_3      = hold_q[3];
    assign ch_valid     = ch_valid_q;
    assign x_adc_select = sel;
    assign locked       = (state_q == RUN);
    assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_x_adc_demux_4ch.sv
// Bench for x_adc_demux_4ch: one instance per SYNC_MODE sharing a stimulus stream.
module tb_x_adc_demux_4ch;
    import x_adc_demux_4ch_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic err_clear;
    x_adc_demux_4ch_if #(.DATA_W(DW)) bus ();

    // Index 1: SYNC_MODE=1 instance, index 0: SYNC_MODE=0 instance.
    logic [NUM_CH-1:0][DW-1:0] reg_s, reg_a;
    logic [3:0] chv_s, chv_a;
    logic       fv_s, fv_a, lk_s, lk_a, err_s, err_a;
    logic [1:0] sel_s, sel_a;

    x_adc_demux_4ch #(.DATA_W(DW), .SYNC_MODE(1'b1)) dut_s (
        .clk(clk), .GlobalReset(rst), .adc(bus), .err_clear(err_clear),
        .x_adc_0(reg_s[0]), .x_adc_1(reg_s[1]), .x_adc_2(reg_s[2]), .x_adc_3(reg_s[3]),
        .ch_valid(chv_s), .frame_valid(fv_s), .x_adc_select(sel_s),
        .locked(lk_s), .sync_err(err_s)
    );

    x_adc_demux_4ch #(.DATA_W(DW), .SYNC_MODE(1'b0)) dut_a (
        .clk(clk), .GlobalReset(rst), .adc(bus), .err_clear(err_clear),
        .x_adc_0(reg_a[0]), .x_adc_1(reg_a[1]), .x_adc_2(reg_a[2]), .x_adc_3(reg_a[3]),
        .ch_valid(chv_a), .frame_valid(fv_a), .x_adc_select(sel_a),
        .locked(lk_a), .sync_err(err_a)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int fv_cnt_s = 0;
    int fv_cnt_a = 0;

    // Reference model: next channel position, run length of consecutive
    // channels since the last channel 0, and a lock flag.
    logic [DW-1:0] m_reg [2][4];
    int            m_pos [2];
    int            m_run [2];
    bit            m_lk  [2];
    bit            m_err [2];
    logic [3:0]    m_chv [2];
    bit            m_fv  [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step(input int m, input bit r, input bit v, input bit s,
                              input bit c, input logic [DW-1:0] d);
        int  ch;
        bit  set;
        m_chv[m] = 4'b0;
        m_fv[m]  = 1'b0;
        if (r) begin
            for (int i = 0; i < 4; i++) m_reg[m][i] = '0;
            m_pos[m] = 0;
            m_run[m] = 0;
            m_lk[m]  = (m == 0);
            m_err[m] = 1'b0;
            return;
        end
        set = v && m_lk[m] && s && (m_pos[m] != 0);
        if (set)    m_err[m] = 1'b1;
        else if (c) m_err[m] = 1'b0;
        if (v && (m_lk[m] || s)) begin
            ch = s ? 0 : m_pos[m];
            m_reg[m][ch] = d;
            m_chv[m] = 4'(1 << ch);
            m_run[m] = (ch == 0) ? 1 : m_run[m] + 1;
            m_fv[m]  = (ch == 3) && (m_run[m] == 4);
            m_pos[m] = (ch + 1) % 4;
            m_lk[m]  = 1'b1;
        end
    endtask

    task automatic compare_dut(input int m);
        string p;
        p = (m == 1) ? "sync" : "auto";
        for (int i = 0; i < 4; i++)
            check($sformatf("%s x_adc_%0d", p, i), (m == 1) ? reg_s[i] : reg_a[i], m_reg[m][i]);
        check({p, " ch_valid"},     (m == 1) ? chv_s : chv_a, m_chv[m]);
        check({p, " frame_valid"},  (m == 1) ? fv_s  : fv_a,  m_fv[m]);
        check({p, " x_adc_select"}, (m == 1) ? sel_s : sel_a, 64'(m_pos[m]));
        check({p, " locked"},       (m == 1) ? lk_s  : lk_a,  m_lk[m]);
        check({p, " sync_err"},     (m == 1) ? err_s : err_a, m_err[m]);
    endtask

    task automatic cycle(input bit r, input bit v, input bit s, input bit c, input logic [DW-1:0] d);
        @(negedge clk);
        rst             = r;
        bus.x_adc_valid = v;
        bus.x_adc_sync  = s;
        bus.x_adc       = d;
        err_clear       = c;
        @(posedge clk);
        model_step(0, r, v, s, c, d);
        model_step(1, r, v, s, c, d);
        #1;
        cyc++;
        if (fv_s === 1'b1) fv_cnt_s++;
        if (fv_a === 1'b1) fv_cnt_a++;
        compare_dut(0);
        compare_dut(1);
    endtask

    typedef struct {
        bit            rst, v, s, clr;
        logic [DW-1:0] d;
        logic [3:0]    chv;
        bit            fv;
        logic [1:0]    sel;
        bit            lk, err;
        logic [DW-1:0] r0;
    } vec_t;

    function automatic vec_t mk(input bit rst, input bit v, input bit s, input bit clr,
                                input logic [DW-1:0] d, input logic [3:0] chv, input bit fv,
                                input logic [1:0] sel, input bit lk, input bit err,
                                input logic [DW-1:0] r0);
        vec_t t;
        t.rst = rst; t.v = v; t.s = s; t.clr = clr; t.d = d;
        t.chv = chv; t.fv = fv; t.sel = sel; t.lk = lk; t.err = err; t.r0 = r0;
        return t;
    endfunction

    vec_t tbl [10];

    initial begin
        int f0, fa;
        rst = 1'b1; err_clear = 1'b0;
        bus.x_adc = '0; bus.x_adc_valid = 1'b0; bus.x_adc_sync = 1'b0;

        // Expected outputs of the SYNC_MODE=1 instance after each vector.
        tbl[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00);
        tbl[1] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h11, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00);
        tbl[2] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h22, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00);
        tbl[3] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'h33, 4'h1, 1'b0, 2'd1, 1'b1, 1'b0, 32'h33);
        tbl[4] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h00);
        tbl[5] = mk(1'b0, 1'b1, 1'b1, 1'b0, 32'hA0, 4'h1, 1'b0, 2'd1, 1'b1, 1'b0, 32'hA0);
        tbl[6] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hA1, 4'h2, 1'b0, 2'd2, 1'b1, 1'b0, 32'hA0);
        tbl[7] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hA2, 4'h4, 1'b0, 2'd3, 1'b1, 1'b0, 32'hA0);
        tbl[8] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'hA3, 4'h8, 1'b1, 2'd0, 1'b1, 1'b0, 32'hA0);
        tbl[9] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 4'h0, 1'b0, 2'd0, 1'b1, 1'b0, 32'hA0);

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].clr, tbl[i].d);
            check($sformatf("vec%0d ch_valid", i),     chv_s,    tbl[i].chv);
            check($sformatf("vec%0d frame_valid", i),  fv_s,     tbl[i].fv);
            check($sformatf("vec%0d x_adc_select", i), sel_s,    tbl[i].sel);
            check($sformatf("vec%0d locked", i),       lk_s,     tbl[i].lk);
            check($sformatf("vec%0d sync_err", i),     err_s,    tbl[i].err);
            check($sformatf("vec%0d x_adc_0", i),      reg_s[0], tbl[i].r0);
        end
        check("basic x_adc_3", reg_s[3], 32'hA3);

        // Gaps inside a frame.
        f0 = fv_cnt_s;
        cycle(0, 1, 1, 0, 32'hB0);
        repeat (3) begin
            cycle(0, 0, 0, 0, 32'h0);
            check("gap select hold", sel_s, 2'd1);
        end
        cycle(0, 1, 0, 0, 32'hB1);
        cycle(0, 0, 0, 0, 32'h0);
        cycle(0, 1, 0, 0, 32'hB2);
        cycle(0, 1, 0, 0, 32'hB3);
        check("gap frame count", 64'(fv_cnt_s - f0), 64'd1);
        check("gap x_adc_1", reg_s[1], 32'hB1);

        // Misalignment and resync.
        f0 = fv_cnt_s;
        cycle(0, 1, 1, 0, 32'hC0);
        cycle(0, 1, 0, 0, 32'hC1);
        cycle(0, 1, 1, 0, 32'hD0);
        check("resync sync_err", err_s, 1'b1);
        cycle(0, 1, 0, 0, 32'hD1);
        cycle(0, 1, 0, 0, 32'hD2);
        cycle(0, 1, 0, 0, 32'hD3);
        check("resync frame count", 64'(fv_cnt_s - f0), 64'd1);
        check("resync x_adc_0", reg_s[0], 32'hD0);
        check("resync x_adc_2 kept", reg_s[2], 32'hD2);
        cycle(0, 0, 0, 1, 32'h0);
        check("err_clear", err_s, 1'b0);
        cycle(0, 1, 1, 0, 32'hC0);
        cycle(0, 1, 0, 0, 32'hC1);
        cycle(0, 1, 1, 1, 32'hD0);
        check("set beats clear", err_s, 1'b1);
        cycle(0, 0, 0, 1, 32'h0);

        // Reset mid-frame.
        cycle(0, 1, 1, 0, 32'hE0);
        cycle(0, 1, 0, 0, 32'hE1);
        cycle(1, 0, 0, 0, 32'h0);
        check("midreset locked", lk_s, 1'b0);
        check("midreset x_adc_0", reg_s[0], 32'h0);
        cycle(0, 1, 0, 0, 32'hE2);
        check("post-reset drop strobe", chv_s, 4'h0);
        check("post-reset drop reg", reg_s[2], 32'h0);

        // SYNC_MODE=0 captures from reset without sync.
        cycle(1, 0, 0, 0, 32'h0);
        check("auto locked from reset", lk_a, 1'b1);
        fa = fv_cnt_a;
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 32'hF0 + 32'(i));
        check("auto x_adc_3", reg_a[3], 32'hF3);
        check("auto frame count", 64'(fv_cnt_a - fa), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(99) < 2), ($urandom_range(99) < 70),
                  ($urandom_range(99) < 15), ($urandom_range(99) < 10), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
